// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, presents it as the fetch address and chooses the next PC
// (sequential, jump from ID, or taken branch from EX). The fetched word is
// captured with a valid bit and split into the fields the decoder needs.
//
// Flow control: this stage has no valid/ready handshake. The downstream
// hazard unit holds it with 'stall'. While stall is high, pc and the IF/ID
// register keep their values. A taken branch overrides stall because the
// branch is the oldest instruction in flight. A jump is honoured only when
// the ID slot holds a real instruction (id_valid=1).
module instruction_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        flush_idex,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [5:0]  op_code,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        jump_go;

  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
  assign jump_go     = jump & id_valid;
  assign flush_idex  = branch_taken;

  // Field outputs are pure slices of the registered instruction, so
  // imem_data never reaches an output combinationally.
  assign op_code  = id_instr[31:26];
  assign rs       = id_instr[25:21];
  assign rt       = id_instr[20:16];
  assign rd       = id_instr[15:11];
  assign shamt    = id_instr[10:6];
  assign funct    = id_instr[5:0];
  assign imm_sext = {{16{id_instr[15]}}, id_instr[15:0]};

  // PC and IF/ID register update: branch > stall > jump > sequential fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= PC_RESET;
      id_instr    <= 32'h0000_0000;
      id_pc_plus4 <= 32'h0000_0000;
      id_valid    <= 1'b0;
    end else if (branch_taken) begin
      // Word alignment is forced on the redirect target.
      pc          <= branch_target & ~32'h0000_0003;
      id_instr    <= 32'h0000_0000;
      id_pc_plus4 <= 32'h0000_0000;
      id_valid    <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
      id_instr    <= id_instr;
      id_pc_plus4 <= id_pc_plus4;
      id_valid    <= id_valid;
    end else if (jump_go) begin
      // The word fetched this cycle is on the wrong path and is dropped.
      pc          <= jump_target;
      id_instr    <= 32'h0000_0000;
      id_pc_plus4 <= 32'h0000_0000;
      id_valid    <= 1'b0;
    end else begin
      pc          <= pc_plus4;
      id_instr    <= imem_data;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: reset, field split, stall,
// jump, branch priority, mid-run reset and PC wrap-around.
module tb_instruction_fetch_stage;

  // clock / reset
  logic clk;
  logic reset_n;
  logic reset_w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // main instance (PC_RESET = 0x40)
  logic [31:0] imem_addr, imem_data, branch_target;
  logic        stall, jump, branch_taken, flush_idex;
  logic [31:0] id_instr, id_pc_plus4, imm_sext;
  logic        id_valid;
  logic [5:0]  op_code, funct;
  logic [4:0]  rs, rt, rd, shamt;

  // wrap instance (PC_RESET = 0xFFFF_FFFC)
  logic [31:0] imem_addr_w, imem_data_w;
  logic        flush_idex_w;
  logic [31:0] id_instr_w, id_pc_plus4_w, imm_sext_w;
  logic        id_valid_w;
  logic [5:0]  op_code_w, funct_w;
  logic [4:0]  rs_w, rt_w, rd_w, shamt_w;

  logic [31:0] imem [0:255];

  assign imem_data   = imem[imem_addr[9:2]];
  assign imem_data_w = ~imem_addr_w;

  instruction_fetch_stage #(.PC_RESET(32'h0000_0040)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .jump(jump),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flush_idex(flush_idex),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .op_code(op_code), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm_sext(imm_sext)
  );

  instruction_fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset_n(reset_w),
    .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .stall(1'b0), .jump(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0000_0000),
    .flush_idex(flush_idex_w),
    .id_instr(id_instr_w), .id_pc_plus4(id_pc_plus4_w), .id_valid(id_valid_w),
    .op_code(op_code_w), .rs(rs_w), .rt(rt_w), .rd(rd_w),
    .shamt(shamt_w), .funct(funct_w), .imm_sext(imm_sext_w)
  );

  int tests_run;
  int tests_failed;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h2000_0000 | (i << 2);
    imem[16] = 32'h8C43_FFFC;   // lw at 0x40
    imem[64] = 32'h0800_0010;   // j 0x40 at 0x100

    reset_n = 1'b0; reset_w = 1'b0;
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0;

    // reset state
    step(); step();
    check("rst_imem_addr", imem_addr, 32'h0000_0040);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'h0);
    check("rst_op_code", {26'b0, op_code}, 32'h0);
    branch_taken = 1'b1;
    #1;
    check("rst_flush_follows", {31'b0, flush_idex}, 32'h1);
    branch_taken = 1'b0;
    #1;
    check("rst_flush_low", {31'b0, flush_idex}, 32'h0);

    // first fetch and field split (lw $3, -4($2))
    reset_n = 1'b1;
    step();
    check("f1_imem_addr", imem_addr, 32'h0000_0044);
    check("f1_id_instr", id_instr, 32'h8C43_FFFC);
    check("f1_id_pc_plus4", id_pc_plus4, 32'h0000_0044);
    check("f1_id_valid", {31'b0, id_valid}, 32'h1);
    check("f1_op_code", {26'b0, op_code}, 32'h23);
    check("f1_rs", {27'b0, rs}, 32'd2);
    check("f1_rt", {27'b0, rt}, 32'd3);
    check("f1_rd", {27'b0, rd}, 32'd31);
    check("f1_shamt", {27'b0, shamt}, 32'd31);
    check("f1_funct", {26'b0, funct}, 32'h3C);
    check("f1_imm_sext", imm_sext, 32'hFFFF_FFFC);

    step();
    check("f2_imem_addr", imem_addr, 32'h0000_0048);
    check("f2_id_instr", id_instr, 32'h2000_0044);
    check("f2_id_pc_plus4", id_pc_plus4, 32'h0000_0048);

    // stall for three cycles
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_imem_addr", imem_addr, 32'h0000_0048);
      check("stall_id_instr", id_instr, 32'h2000_0044);
      check("stall_id_valid", {31'b0, id_valid}, 32'h1);
    end
    stall = 1'b0;
    step();
    check("resume_id_instr", id_instr, 32'h2000_0048);
    check("resume_id_pc_plus4", id_pc_plus4, 32'h0000_004C);
    check("resume_imem_addr", imem_addr, 32'h0000_004C);

    // run sequentially to 0x100 where the jump lives
    guard = 0;
    while (imem_addr !== 32'h0000_0100 && guard < 100) begin
      step();
      guard++;
    end
    check("reach_0x100", imem_addr, 32'h0000_0100);
    step();
    check("j_id_instr", id_instr, 32'h0800_0010);
    check("j_id_pc_plus4", id_pc_plus4, 32'h0000_0104);

    // jump: one bubble, then target word; jump held on the bubble is ignored
    jump = 1'b1;
    step();
    check("j_imem_addr", imem_addr, 32'h0000_0040);
    check("j_bubble_valid", {31'b0, id_valid}, 32'h0);
    check("j_bubble_instr", id_instr, 32'h0);
    step();
    jump = 1'b0;
    check("j_target_instr", id_instr, 32'h8C43_FFFC);
    check("j_target_valid", {31'b0, id_valid}, 32'h1);
    check("j_target_imem_addr", imem_addr, 32'h0000_0044);

    // branch beats stall and jump; target low bits cleared
    branch_taken = 1'b1; branch_target = 32'h0000_0203;
    stall = 1'b1; jump = 1'b1;
    #1;
    check("br_flush_idex", {31'b0, flush_idex}, 32'h1);
    step();
    branch_taken = 1'b0; stall = 1'b0; jump = 1'b0;
    check("br_imem_addr", imem_addr, 32'h0000_0200);
    check("br_id_valid", {31'b0, id_valid}, 32'h0);
    check("br_id_instr", id_instr, 32'h0);
    check("br_id_pc_plus4", id_pc_plus4, 32'h0);
    #1;
    check("br_flush_low", {31'b0, flush_idex}, 32'h0);
    step();
    check("br_next_instr", id_instr, 32'h2000_0200);
    check("br_next_imem_addr", imem_addr, 32'h0000_0204);

    // reset mid-operation takes effect without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_imem_addr", imem_addr, 32'h0000_0040);
    check("mid_rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("mid_rst_id_instr", id_instr, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("mid_rst_first_fetch", id_instr, 32'h8C43_FFFC);

    // PC wrap-around on the second instance
    check("wrap_rst_imem_addr", imem_addr_w, 32'hFFFF_FFFC);
    reset_w = 1'b1;
    step();
    check("wrap_imem_addr", imem_addr_w, 32'h0000_0000);
    check("wrap_id_pc_plus4", id_pc_plus4_w, 32'h0000_0000);
    check("wrap_id_instr", id_instr_w, 32'h0000_0003);
    check("wrap_id_valid", {31'b0, id_valid_w}, 32'h1);
    step();
    check("wrap2_imem_addr", imem_addr_w, 32'h0000_0004);
    check("wrap2_id_instr", id_instr_w, 32'hFFFF_FFFF);
    check("wrap2_id_pc_plus4", id_pc_plus4_w, 32'h0000_0004);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS datapath, sitting directly upstream of `unidad_de_control`. It holds the PC, drives the instruction-memory address and selects the next PC (sequential, jump or taken-branch redirect). It registers the fetched word with a valid bit and splits it into fields, including the `op_code` consumed by the control unit.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset; low two bits must be 00
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  fetch address, always equal to current PC
- imem_data  in  32  instruction word at imem_addr, combinational (same cycle)
- stall  in  1  hazard hold: freeze PC and IF/ID
- jump  in  1  control-unit `jump` for the instruction currently in ID
- branch_taken  in  1  branch in EX resolved taken (branch & condition)
- branch_target  in  32  EX-computed branch target
- flush_idex  out  1  combinational copy of branch_taken, for the ID/EX register
- id_instr  out  32  registered instruction in ID
- id_pc_plus4  out  32  registered PC+4 of the ID instruction
- id_valid  out  1  ID holds a real instruction (0 = bubble)
- op_code  out  6  id_instr[31:26]
- rs, rt, rd  out  5 each  id_instr[25:21], [20:16], [15:11]
- shamt  out  5  id_instr[10:6]
- funct  out  6  id_instr[5:0]
- imm_sext  out  32  id_instr[15:0] sign-extended

## Operation
- Registers: pc, id_instr, id_pc_plus4, id_valid. Field outputs are pure slices of id_instr.
- Reset values (asynchronous, while reset_n=0): pc=PC_RESET, id_instr=0, id_pc_plus4=0, id_valid=0. All field outputs are therefore 0, and flush_idex follows branch_taken.
- pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- jump_target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
- jump_go = jump & id_valid. A jump input asserted on a bubble is ignored.
- Redirect targets have bits [1:0] forced to 00 before loading pc.
- Next-state priority, evaluated each rising edge:
  1. branch_taken: pc<=branch_target; IF/ID<=bubble. Overrides stall and jump; the branch is the oldest instruction.
  2. stall: pc, id_instr, id_pc_plus4 and id_valid hold. A pending jump in ID stays held and redirects after stall drops.
  3. jump_go: pc<=jump_target; IF/ID<=bubble, discarding the word fetched this cycle.
  4. Otherwise: pc<=pc_plus4; id_instr<=imem_data; id_pc_plus4<=pc_plus4; id_valid<=1.
- Bubble: id_instr=32'h0000_0000 (sll $0,$0,0), id_pc_plus4=0, id_valid=0.
- Reset asserted mid-operation: all registers return to reset values immediately. The first fetch after release is at PC_RESET.

## Timing
- One fetch per cycle when unstalled. Instruction fetched in cycle N is in ID (id_instr valid) in cycle N+1.
- Jump penalty: 1 bubble. Jump in ID at cycle N means pc=jump_target at N+1 and id_valid=0 at N+1.
- Branch penalty: 2 instructions. branch_taken at cycle N flushes IF/ID at N+1 and asserts flush_idex during N. pc=branch_target at N+1.
- flush_idex has zero latency (combinational). All other outputs change only on the clk edge or on reset assertion.
- No combinational path from imem_data to any output.

## Test plan
- Reset: hold reset_n=0 with PC_RESET=0x0000_0040. Required: imem_addr=0x40, id_valid=0, id_instr=0. Release and give one edge: imem_addr=0x44, id_instr = word at 0x40, id_pc_plus4=0x44.
- Sequential plus fields: imem_data=0x8C43_FFFC (lw). Next cycle: op_code=6'b100011, rs=2, rt=3, imm_sext=0xFFFF_FFFC, id_valid=1.
- Stall: assert stall for 3 cycles mid-stream. Required: imem_addr, id_instr and id_valid are unchanged throughout. Fetch resumes at the same PC on the cycle after stall drops.
- Jump: id_instr=0x0800_0010 with id_pc_plus4=0x0000_0104 and jump=1. Next cycle: imem_addr=0x0000_0040, id_valid=0. The following cycle: the word at 0x40 is in ID.
- Branch vs stall vs jump: assert branch_taken=1, branch_target=0x0000_0203, stall=1 and jump=1 (ID valid) together. Required: flush_idex=1 that cycle. Next cycle: imem_addr=0x0000_0200, id_valid=0.
- Wrap: reset with PC_RESET=0xFFFF_FFFC and run 2 cycles. Required: imem_addr goes 0xFFFF_FFFC then 0x0000_0000. id_pc_plus4 of the first word = 0x0000_0000.
